// File: rtl/halflife_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// halflife_pkg : shared states and constants for the half-life driver
// Revision     : 1.0
// ------------------------------------------------------------------
package halflife_pkg;

  localparam int HALV_W = 4;
  localparam logic [HALV_W-1:0] HALV_MAX = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WAIT = 3'd2,
    S_DEC  = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/halflife_if.sv
`default_nettype none
// ------------------------------------------------------------------
// halflife_if : request/command bundle between requester and driver
// Revision    : 1.0
// ------------------------------------------------------------------
interface halflife_if #(
  parameter int N  = 4,
  parameter int PW = 8
) ();
  import halflife_pkg::*;

  logic              start;
  logic [N-1:0]      init;
  logic [PW-1:0]     period;
  logic              abort;
  logic              cmd_load;
  logic [N-1:0]      load_val;
  logic              cmd_down;
  logic [N-1:0]      shadow;
  logic [HALV_W-1:0] halvings;
  logic              busy;
  logic              done;

  modport master (
    output start, init, period, abort,
    input  cmd_load, load_val, cmd_down, shadow, halvings, busy, done
  );

  modport slave (
    input  start, init, period, abort,
    output cmd_load, load_val, cmd_down, shadow, halvings, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/halflife_prescaler.sv
`default_nettype none
// ------------------------------------------------------------------
// halflife_prescaler : WAIT-phase timer, expires period cycles after reload
// Revision           : 1.0
// ------------------------------------------------------------------
module halflife_prescaler #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          reload,
  input  logic [PW-1:0] period,
  output logic          expire
);

  logic [PW-1:0] cnt_q, cnt_d;

  // Counts period-1 down to 0 and parks there; the 0 cycle is the last one.
  always_comb begin
    cnt_d = cnt_q;
    if (reload) begin
      cnt_d = (period == '0) ? '0 : period - 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/halflife_driver.sv
`default_nettype none
// ------------------------------------------------------------------
// halflife_driver : drives a down-counter through successive halvings
// Revision        : 1.0
// ------------------------------------------------------------------
module halflife_driver #(
  parameter int N  = 4,
  parameter int PW = 8
) (
  input  logic     clk,
  input  logic     rst,
  halflife_if.slave bus
);
  import halflife_pkg::*;

  state_e            state_q, state_d;
  logic [N-1:0]      init_q, init_d;
  logic [PW-1:0]     period_q, period_d;
  logic [N-1:0]      shadow_q, shadow_d;
  logic [N-1:0]      rem_q, rem_d;
  logic [HALV_W-1:0] halv_q, halv_d;
  logic              reload;
  logic              expire;
  logic              cmd_load, cmd_down, done;

  halflife_prescaler #(.PW(PW)) u_presc (
    .clk    (clk),
    .rst    (rst),
    .reload (reload),
    .period (period_q),
    .expire (expire)
  );

  always_comb begin
    state_d  = state_q;
    init_d   = init_q;
    period_d = period_q;
    shadow_d = shadow_q;
    rem_d    = rem_q;
    halv_d   = halv_q;
    reload   = 1'b0;
    cmd_load = 1'b0;
    cmd_down = 1'b0;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          init_d   = bus.init;
          period_d = (bus.period == '0) ? PW'(1) : bus.period;
          halv_d   = '0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        cmd_load = 1'b1;
        shadow_d = init_q;
        if (init_q <= N'(1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          reload  = 1'b1;
        end
      end
      S_WAIT: begin
        if (expire) begin
          state_d = S_DEC;
          rem_d   = shadow_q - (shadow_q >> 1);
        end
      end
      S_DEC: begin
        cmd_down = 1'b1;
        shadow_d = (shadow_q != '0) ? shadow_q - 1'b1 : '0;
        rem_d    = (rem_q != '0) ? rem_q - 1'b1 : '0;
        if (rem_q <= N'(1)) begin
          halv_d = (halv_q == HALV_MAX) ? halv_q : halv_q + 1'b1;
          // shadow_q is pre-strobe here, so <=2 means <=1 after this strobe
          if (shadow_q <= N'(2)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            reload  = 1'b1;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort freezes the datapath and kills every strobe in the same cycle.
    if (bus.abort && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      shadow_d = shadow_q;
      rem_d    = rem_q;
      halv_d   = halv_q;
      reload   = 1'b0;
      cmd_load = 1'b0;
      cmd_down = 1'b0;
      done     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      init_q   <= '0;
      period_q <= PW'(1);
      shadow_q <= '0;
      rem_q    <= '0;
      halv_q   <= '0;
    end else begin
      state_q  <= state_d;
      init_q   <= init_d;
      period_q <= period_d;
      shadow_q <= shadow_d;
      rem_q    <= rem_d;
      halv_q   <= halv_d;
    end
  end

  assign bus.cmd_load = cmd_load;
  assign bus.cmd_down = cmd_down;
  assign bus.done     = done;
  assign bus.load_val = init_q;
  assign bus.shadow   = shadow_q;
  assign bus.halvings = halv_q;
  assign bus.busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_halflife_driver.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_halflife_driver : directed self-checking bench for halflife_driver
// Revision           : 1.0
// ------------------------------------------------------------------
module tb_halflife_driver;
  import halflife_pkg::*;

  logic clk = 1'b0;
  logic rst;

  halflife_if #(.N(4), .PW(8)) bus ();

  halflife_driver #(.N(4), .PW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Observed-behaviour recorder, sampled mid-cycle.
  int n_load, n_down, n_done, n_bad, last_load, cur_burst, cur_gap;
  int bursts[$];
  int shadows[$];
  int gaps[$];

  always @(negedge clk) begin
    if (bus.cmd_load) begin
      n_load++;
      last_load = int'(bus.load_val);
    end
    if (bus.cmd_load && bus.cmd_down) n_bad++;
    if (!bus.busy && (bus.cmd_load || bus.cmd_down)) n_bad++;
    if (bus.done) n_done++;
    if (bus.cmd_down) begin
      n_down++;
      cur_burst++;
    end else if (cur_burst > 0) begin
      bursts.push_back(cur_burst);
      shadows.push_back(int'(bus.shadow));
      cur_burst = 0;
    end
    if (bus.busy && !bus.cmd_load && !bus.cmd_down && !bus.done) begin
      cur_gap++;
    end else if (cur_gap > 0) begin
      gaps.push_back(cur_gap);
      cur_gap = 0;
    end
  end

  function automatic int pack(input int q[$]);
    int v = 0;
    foreach (q[i]) v = v * 10 + q[i];
    return v;
  endfunction

  task automatic clear_stats();
    n_load = 0; n_down = 0; n_done = 0; n_bad = 0;
    last_load = -1; cur_burst = 0; cur_gap = 0;
    bursts.delete(); shadows.delete(); gaps.delete();
  endtask

  task automatic pulse_start(input int iv, input int pv);
    bus.init   = 4'(iv);
    bus.period = 8'(pv);
    bus.start  = 1'b1;
    @(negedge clk); #1;
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (n_done == 0 && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    chk({tag, "_timeout"}, (n_done == 0) ? 1 : 0, 0);
    @(negedge clk); #1;
  endtask

  task automatic check_run(input string tag, input int e_load, input int e_gaps,
                           input int e_bursts, input int e_shadows, input int e_down,
                           input int e_halv, input int e_shadow);
    chk({tag, "_loadval"}, last_load, e_load);
    chk({tag, "_nload"},   n_load, 1);
    chk({tag, "_gaps"},    pack(gaps), e_gaps);
    chk({tag, "_bursts"},  pack(bursts), e_bursts);
    chk({tag, "_shadows"}, pack(shadows), e_shadows);
    chk({tag, "_ndown"},   n_down, e_down);
    chk({tag, "_ndone"},   n_done, 1);
    chk({tag, "_halv"},    int'(bus.halvings), e_halv);
    chk({tag, "_shadow"},  int'(bus.shadow), e_shadow);
    chk({tag, "_busy"},    int'(bus.busy), 0);
    chk({tag, "_strobe"},  n_bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; bus.start = 1'b0; bus.abort = 1'b0;
    bus.init = '0; bus.period = '0;
    clear_stats();
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_shadow", int'(bus.shadow), 0);
    chk("rst_halv", int'(bus.halvings), 0);
    chk("rst_loadval", int'(bus.load_val), 0);
    chk("rst_strobes", int'(bus.cmd_load | bus.cmd_down | bus.done), 0);
    @(negedge clk); #1;
    rst = 1'b0;

    // Normal run, started in the first cycle after reset release.
    clear_stats();
    pulse_start(9, 3);
    chk("first_start_load", n_load, 1);
    wait_done("normal");
    check_run("normal", 9, 333, 521, 421, 8, 3, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("hold_shadow", int'(bus.shadow), 1);
    chk("hold_halv", int'(bus.halvings), 3);

    // Trivial runs.
    clear_stats();
    pulse_start(1, 5);
    wait_done("triv1");
    check_run("triv1", 1, 0, 0, 0, 0, 0, 1);
    clear_stats();
    pulse_start(0, 5);
    wait_done("triv0");
    check_run("triv0", 0, 0, 0, 0, 0, 0, 0);

    // Zero period behaves as one cycle.
    clear_stats();
    pulse_start(15, 0);
    wait_done("zper");
    check_run("zper", 15, 111, 842, 731, 14, 3, 1);

    // Abort in the third strobe of the first burst.
    clear_stats();
    pulse_start(9, 3);
    k = 0;
    while (n_down < 2 && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    chk("abort_reach", n_down, 2);
    @(posedge clk); #1;
    bus.abort = 1'b1;
    #1;
    chk("abort_down_gated", int'(bus.cmd_down), 0);
    chk("abort_load_gated", int'(bus.cmd_load), 0);
    chk("abort_shadow_in", int'(bus.shadow), 7);
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("abort_idle", int'(bus.busy), 0);
    chk("abort_shadow", int'(bus.shadow), 7);
    repeat (5) @(negedge clk);
    #1;
    chk("abort_ndone", n_done, 0);
    chk("abort_ndown", n_down, 2);
    chk("abort_halv", int'(bus.halvings), 0);

    // Abort together with start in IDLE is ignored.
    clear_stats();
    bus.abort = 1'b1;
    pulse_start(9, 3);
    bus.abort = 1'b0;
    chk("abort_start_busy", int'(bus.busy), 0);
    chk("abort_start_nload", n_load, 0);

    // Reset mid-WAIT, then restart immediately after release.
    clear_stats();
    pulse_start(9, 3);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mrst_busy", int'(bus.busy), 0);
    chk("mrst_shadow", int'(bus.shadow), 0);
    chk("mrst_halv", int'(bus.halvings), 0);
    chk("mrst_loadval", int'(bus.load_val), 0);
    chk("mrst_strobes", int'(bus.cmd_load | bus.cmd_down | bus.done), 0);
    #2;
    rst = 1'b0;
    clear_stats();
    pulse_start(4, 2);
    wait_done("mrst_run");
    check_run("mrst_run", 4, 22, 21, 21, 3, 2, 1);

    // Start while busy is ignored.
    clear_stats();
    pulse_start(9, 3);
    @(negedge clk); #1;
    bus.init = 4'd2; bus.period = 8'd7; bus.start = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    chk("busy_loadval", int'(bus.load_val), 9);
    wait_done("busy_run");
    check_run("busy_run", 9, 333, 521, 421, 8, 3, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
